// File: rtl/bk_multiword_add_seq.sv
// bk_multiword_add_seq
//   Performs NWORDS x 32-bit add (and optionally subtract) by time-multiplexing one external
//   32-bit adder. One word per cycle, least significant word first. The inter-word carry
//   lives in r_carry.
//
// Build option:
//   BK_SEQ_SUB_EN - when defined, i_in_op selects subtract (B inverted, initial carry 1,
//                   o_out_cout = NOT borrow). When undefined, i_in_op is ignored (add only).
//
// Ports:
//   i_clk, i_rst_n              clock, synchronous active-low reset
//   i_in_valid / o_in_ready     request handshake; i_in_a, i_in_b, i_in_cin, i_in_op operands
//   o_out_valid / i_out_ready   result handshake; o_out_s, o_out_cout result
//   o_add_a, o_add_b, o_add_cin operand word and carry to the shared adder (0 outside RUN)
//   i_add_s, i_add_cout         combinational result from the shared adder
//   o_busy                      high while the shared adder is owned (RUN)
module bk_multiword_add_seq #(
   parameter int unsigned NWORDS = 4,
   parameter int unsigned IDXW   = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_in_valid,
   output logic                  o_in_ready,
   input  logic [32*NWORDS-1:0]  i_in_a,
   input  logic [32*NWORDS-1:0]  i_in_b,
   input  logic                  i_in_cin,
   input  logic                  i_in_op,
   output logic                  o_out_valid,
   input  logic                  i_out_ready,
   output logic [32*NWORDS-1:0]  o_out_s,
   output logic                  o_out_cout,
   output logic [31:0]           o_add_a,
   output logic [31:0]           o_add_b,
   output logic                  o_add_cin,
   input  logic [31:0]           i_add_s,
   input  logic                  i_add_cout,
   output logic                  o_busy
);

   localparam int unsigned      W       = 32 * NWORDS;
   localparam logic [IDXW-1:0]  LastIdx = IDXW'(NWORDS - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e          r_state, w_state_next;
   logic [W-1:0]    r_a, r_b, r_s;
   logic            r_carry, r_cout;
   logic [IDXW-1:0] r_idx;
   logic [31:0]     w_a_word, w_b_word;
   logic            w_accept, w_last, w_carry_init;

`ifdef BK_SEQ_SUB_EN
   logic r_op;
   // Subtract is A + ~B + 1, so the first word's carry-in is forced to 1.
   assign w_carry_init = i_in_op ? 1'b1 : i_in_cin;
`else
   logic w_unused_op;
   assign w_unused_op  = i_in_op;
   assign w_carry_init = i_in_cin;
`endif

   assign w_accept = (r_state == StIdle) && i_in_valid;
   assign w_last   = (r_idx == LastIdx);

   // Select the current operand words; constant-index loop avoids out-of-range selects.
   always_comb begin
      w_a_word = '0;
      w_b_word = '0;
      for (int k = 0; k < NWORDS; k++) begin
         if (r_idx == IDXW'(k)) begin
            w_a_word = r_a[32*k +: 32];
            w_b_word = r_b[32*k +: 32];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      o_in_ready   = 1'b0;
      o_out_valid  = 1'b0;
      o_busy       = 1'b0;
      o_add_a      = '0;
      o_add_b      = '0;
      o_add_cin    = 1'b0;
      unique case (r_state)
         StIdle: begin
            o_in_ready = 1'b1;
            if (i_in_valid) begin
               w_state_next = StRun;
            end
         end
         StRun: begin
            o_busy    = 1'b1;
            o_add_a   = w_a_word;
`ifdef BK_SEQ_SUB_EN
            o_add_b   = r_op ? ~w_b_word : w_b_word;
`else
            o_add_b   = w_b_word;
`endif
            o_add_cin = r_carry;
            if (w_last) begin
               w_state_next = StDone;
            end
         end
         StDone: begin
            o_out_valid = 1'b1;
            if (i_out_ready) begin
               w_state_next = StIdle;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_s     <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_idx   <= '0;
`ifdef BK_SEQ_SUB_EN
         r_op    <= 1'b0;
`endif
      end else if (w_accept) begin
         r_a     <= i_in_a;
         r_b     <= i_in_b;
         r_carry <= w_carry_init;
         r_idx   <= '0;
`ifdef BK_SEQ_SUB_EN
         r_op    <= i_in_op;
`endif
      end else if (r_state == StRun) begin
         for (int k = 0; k < NWORDS; k++) begin
            if (r_idx == IDXW'(k)) begin
               r_s[32*k +: 32] <= i_add_s;
            end
         end
         r_carry <= i_add_cout;
         r_idx   <= r_idx + 1'b1;
         if (w_last) begin
            r_cout <= i_add_cout;
         end
      end
   end

   assign o_out_s    = r_s;
   assign o_out_cout = r_cout;

endmodule

// File: tb/tb_bk_multiword_add_seq.sv
// Self-checking bench for bk_multiword_add_seq (NWORDS = 4). Models the shared adder
// combinationally and checks results against a plain-arithmetic reference.
module tb_bk_multiword_add_seq;

   localparam int unsigned NWORDS = 4;
   localparam int unsigned IDXW   = 4;
   localparam int unsigned W      = 32 * NWORDS;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready, in_cin, in_op;
   logic [W-1:0]  in_a, in_b;
   logic          out_valid, out_ready, out_cout;
   logic [W-1:0]  out_s;
   logic [31:0]   add_a, add_b, add_s;
   logic          add_cin, add_cout, busy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   // Shared adder stand-in.
   assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_cin};

   bk_multiword_add_seq #(
      .NWORDS (NWORDS),
      .IDXW   (IDXW)
   ) u_dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_in_a      (in_a),
      .i_in_b      (in_b),
      .i_in_cin    (in_cin),
      .i_in_op     (in_op),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_out_s     (out_s),
      .o_out_cout  (out_cout),
      .o_add_a     (add_a),
      .o_add_b     (add_b),
      .o_add_cin   (add_cin),
      .i_add_s     (add_s),
      .i_add_cout  (add_cout),
      .o_busy      (busy)
   );

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic eff_op(input logic op);
`ifdef BK_SEQ_SUB_EN
      return op;
`else
      return 1'b0 & op;
`endif
   endfunction

   // Reference: {cout, s}. Sub gives A-B mod 2^W with cout = (A >= B).
   function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic op);
      logic [W:0] r;
      if (eff_op(op)) begin
         r[W-1:0] = a - b;
         r[W]     = (a >= b);
      end else begin
         r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      end
      return r;
   endfunction

   function automatic logic [W-1:0] rnd_w();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Issue one request starting at a negedge, wait for the result, optionally hold it
   // under backpressure, then complete the output handshake.
   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic op, input int hold, input logic chk_cin1,
                         output logic [W-1:0] s, output logic cout);
      logic [W:0]  exp;
      logic [31:0] exp_b;
      int          lat, busy_cnt, wait_cnt;
      exp       = ref_op(a, b, cin, op);
      out_ready = 1'b0;
      in_a      = a;
      in_b      = b;
      in_cin    = cin;
      in_op     = op;
      in_valid  = 1'b1;
      wait_cnt  = 0;
      while (!in_ready && wait_cnt < 20) begin
         @(negedge clk);
         wait_cnt++;
      end
      check_eq({tag, "_in_ready"}, in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      in_a     = rnd_w();
      in_b     = rnd_w();
      in_cin   = 1'(($urandom));
      lat      = 0;
      busy_cnt = 0;
      while (!out_valid && lat < 20) begin
         if (busy && lat < NWORDS) begin
            busy_cnt++;
            exp_b = b[32*lat +: 32];
            if (eff_op(op)) exp_b = ~exp_b;
            check_eq({tag, "_add_a"}, add_a, a[32*lat +: 32]);
            check_eq({tag, "_add_b"}, add_b, exp_b);
            if (chk_cin1) check_eq({tag, "_add_cin"}, add_cin, 1);
         end
         @(negedge clk);
         lat++;
      end
      check_eq({tag, "_latency"}, lat, NWORDS);
      check_eq({tag, "_busy_cycles"}, busy_cnt, NWORDS);
      s    = out_s;
      cout = out_cout;
      check_eq({tag, "_s"}, s, exp[W-1:0]);
      check_eq({tag, "_cout"}, cout, exp[W]);
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'(($urandom));
         in_a     = rnd_w();
         @(negedge clk);
         check_eq({tag, "_hold_s"}, out_s, s);
         check_eq({tag, "_hold_cout"}, out_cout, cout);
         check_eq({tag, "_hold_in_ready"}, in_ready, 0);
         check_eq({tag, "_hold_valid"}, out_valid, 1);
         check_eq({tag, "_hold_busy"}, busy, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_eq({tag, "_post_hs_ready"}, in_ready, 1);
      check_eq({tag, "_post_hs_valid"}, out_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] s, ba[3], bb[3];
      logic         c;
      logic [W:0]   e;
      int           acc[3];
      int           sent, got, cyc;
      logic         pend;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_cin    = 1'b0;
      in_op     = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rst_in_ready", in_ready, 1);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_out_s", out_s, 0);
      check_eq("rst_out_cout", out_cout, 0);
      check_eq("rst_add_a", add_a, 0);
      check_eq("rst_add_b", add_b, 0);
      check_eq("rst_add_cin", add_cin, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Inter-word carry.
      run_op("carry", W'(32'h88B388B3), W'(32'h88B188B1), 1'b0, 1'b0, 0, 1'b0, s, c);
      check_eq("carry_s_const", s, 128'h0000_0000_0000_0000_0000_0001_1165_1164);
      check_eq("carry_cout_const", c, 0);

      // Full ripple.
      run_op("ripple", {W{1'b1}}, '0, 1'b1, 1'b0, 0, 1'b1, s, c);
      check_eq("ripple_s_const", s, 0);
      check_eq("ripple_cout_const", c, 1);

`ifdef BK_SEQ_SUB_EN
      run_op("sub_pos", W'(7), W'(5), 1'b0, 1'b1, 0, 1'b0, s, c);
      check_eq("sub_pos_s_const", s, 2);
      check_eq("sub_pos_cout_const", c, 1);
      run_op("sub_neg", W'(5), W'(7), 1'b0, 1'b1, 0, 1'b0, s, c);
      check_eq("sub_neg_s_const", s, {128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE});
      check_eq("sub_neg_cout_const", c, 0);
`else
      run_op("sub_off", W'(5), W'(7), 1'b0, 1'b1, 0, 1'b0, s, c);
      check_eq("sub_off_s_const", s, 12);
      check_eq("sub_off_cout_const", c, 0);
`endif

      // Backpressure with in_valid/in_a churn while the result is held.
      run_op("bp", rnd_w(), rnd_w(), 1'b1, 1'b0, 6, 1'b0, s, c);

      // Reset during the second RUN cycle.
      in_a     = rnd_w();
      in_b     = rnd_w();
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("mid_rst_busy_before", busy, 1);
      rst_n = 1'b0;
      @(negedge clk);
      check_eq("mid_rst_busy", busy, 0);
      check_eq("mid_rst_out_valid", out_valid, 0);
      check_eq("mid_rst_in_ready", in_ready, 1);
      check_eq("mid_rst_add_a", add_a, 0);
      check_eq("mid_rst_add_b", add_b, 0);
      check_eq("mid_rst_add_cin", add_cin, 0);
      rst_n = 1'b1;
      run_op("after_rst", W'(32'h10), W'(32'h20), 1'b0, 1'b0, 0, 1'b0, s, c);
      check_eq("after_rst_s_const", s, 128'h30);

      // Back-to-back with in_valid and out_ready held high.
      for (int i = 0; i < 3; i++) begin
         ba[i]  = W'(i + 1);
         bb[i]  = W'(i + 1) << 96;
         acc[i] = 0;
      end
      out_ready = 1'b1;
      in_cin    = 1'b0;
      in_op     = 1'b0;
      in_a      = ba[0];
      in_b      = bb[0];
      in_valid  = 1'b1;
      sent      = 0;
      got       = 0;
      cyc       = 0;
      pend      = 1'b0;
      while (got < 3 && cyc < 100) begin
         if (pend) begin
            pend = 1'b0;
            if (sent < 3) begin
               in_a = ba[sent];
               in_b = bb[sent];
            end else begin
               in_valid = 1'b0;
            end
         end
         if (in_ready && in_valid) begin
            acc[sent] = cyc;
            sent++;
            pend = 1'b1;
         end
         if (out_valid) begin
            e = ref_op(ba[got], bb[got], 1'b0, 1'b0);
            check_eq("b2b_s", out_s, e[W-1:0]);
            check_eq("b2b_cout", out_cout, e[W]);
            got++;
         end
         @(negedge clk);
         cyc++;
      end
      check_eq("b2b_count", got, 3);
      check_eq("b2b_spacing_1", acc[1] - acc[0], NWORDS + 2);
      check_eq("b2b_spacing_2", acc[2] - acc[1], NWORDS + 2);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);

      // Random operations with random backpressure.
      for (int i = 0; i < 20; i++) begin
         run_op("rand", rnd_w(), rnd_w(), 1'(($urandom)), 1'(($urandom)),
                int'($urandom_range(0, 3)), 1'b0, s, c);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
